// File: rtl/sram_arbiter_if.sv
// Pipeline-side request/response bundle for the SRAM arbiter (fetch port + data port).
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_done;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_done;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    input  inst_done, inst_rdata, data_done, data_rdata
  );
  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    output inst_done, inst_rdata, data_done, data_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-SRAM arbiter: one bus-cycle FSM per SRAM so fetch and data run in parallel
// on different chips; on a shared chip the data port wins.

module sram_chan #(
  parameter int RD_WAIT  = 1,
  parameter int WE_WIDTH = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_ireq,
  input  logic [19:0] i_iaddr,
  input  logic        i_dreq,
  input  logic [3:0]  i_dwe,
  input  logic [19:0] i_daddr,
  input  logic [31:0] i_dwdata,
  input  logic [31:0] i_din,
  output logic        o_ce_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  output logic [3:0]  o_be_n,
  output logic [19:0] o_addr,
  output logic [31:0] o_dout,
  output logic        o_drv,
  output logic        o_idone,
  output logic        o_ddone,
  output logic [31:0] o_rdata
);
  localparam int MAXC = (RD_WAIT > WE_WIDTH) ? RD_WAIT : WE_WIDTH;
  localparam int CW   = $clog2(MAXC + 1) + 1;

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_WE, WR_HD, DONE} st_t;

  st_t           r_st, w_ns;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_own, w_own;
  logic          r_ce_n, r_oe_n, r_we_n, r_drv, r_idone, r_ddone;
  logic          w_ce_n, w_oe_n, w_we_n, w_drv;
  logic [3:0]    r_be_n, w_be_n;
  logic [19:0]   r_addr, w_addr, w_addr_src;
  logic [31:0]   r_dout, w_dout, r_rdata;

  // r_own: 1 = data port owns the channel, 0 = fetch port
  always_comb begin
    w_ns  = r_st;
    w_cnt = r_cnt;
    w_own = r_own;
    case (r_st)
      IDLE: begin
        if (i_dreq) begin
          w_own = 1'b1;
          w_ns  = (|i_dwe) ? WR_SU : RD;
        end else if (i_ireq) begin
          w_own = 1'b0;
          w_ns  = RD;
        end
      end
      RD:      if (r_cnt == CW'(RD_WAIT)) w_ns = DONE;
               else w_cnt = r_cnt + 1'b1;
      WR_SU:   w_ns = WR_WE;
      WR_WE:   if (r_cnt == CW'(WE_WIDTH - 1)) w_ns = WR_HD;
               else w_cnt = r_cnt + 1'b1;
      WR_HD:   w_ns = DONE;
      DONE:    w_ns = IDLE;
      default: w_ns = IDLE;
    endcase
    if (w_ns != r_st) w_cnt = '0;
  end

  // Pins are registered from the next state; in IDLE the request fields are
  // taken straight from the winning port, afterwards the pin registers hold them.
  always_comb begin
    w_addr_src = (r_st == IDLE) ? (i_dreq ? i_daddr : i_iaddr) : r_addr;
    w_ce_n = 1'b1;
    w_oe_n = 1'b1;
    w_we_n = 1'b1;
    w_be_n = 4'hF;
    w_addr = '0;
    w_dout = '0;
    w_drv  = 1'b0;
    case (w_ns)
      RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = 4'h0;
        w_addr = w_addr_src;
      end
      WR_SU, WR_WE, WR_HD: begin
        w_ce_n = 1'b0;
        w_we_n = (w_ns != WR_WE);
        w_drv  = 1'b1;
        w_addr = w_addr_src;
        w_be_n = (r_st == IDLE) ? ~i_dwe : r_be_n;
        w_dout = (r_st == IDLE) ? i_dwdata : r_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_st    <= IDLE;
      r_cnt   <= '0;
      r_own   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= 4'hF;
      r_addr  <= '0;
      r_dout  <= '0;
      r_drv   <= 1'b0;
      r_idone <= 1'b0;
      r_ddone <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_st    <= w_ns;
      r_cnt   <= w_cnt;
      r_own   <= w_own;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_be_n  <= w_be_n;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
      r_drv   <= w_drv;
      r_idone <= (w_ns == DONE) & ~w_own;
      r_ddone <= (w_ns == DONE) & w_own;
      if (w_ns == DONE) r_rdata <= (r_st == RD) ? i_din : '0;
    end
  end

  assign o_ce_n  = r_ce_n;
  assign o_oe_n  = r_oe_n;
  assign o_we_n  = r_we_n;
  assign o_be_n  = r_be_n;
  assign o_addr  = r_addr;
  assign o_dout  = r_dout;
  assign o_drv   = r_drv;
  assign o_idone = r_idone;
  assign o_ddone = r_ddone;
  assign o_rdata = r_rdata;
endmodule

module sram_arbiter #(
  parameter int RD_WAIT  = 1,
  parameter int WE_WIDTH = 1
) (
  input  logic         clk,
  input  logic         resetn,
  sram_arbiter_if.slave bus,
  inout  wire  [31:0]  base_ram_data,
  output logic [19:0]  base_ram_addr,
  output logic [3:0]   base_ram_be_n,
  output logic         base_ram_ce_n,
  output logic         base_ram_oe_n,
  output logic         base_ram_we_n,
  inout  wire  [31:0]  ext_ram_data,
  output logic [19:0]  ext_ram_addr,
  output logic [3:0]   ext_ram_be_n,
  output logic         ext_ram_ce_n,
  output logic         ext_ram_oe_n,
  output logic         ext_ram_we_n
);
  localparam int NCH = 2;

  logic                      w_iok, w_dok, w_unused;
  logic [NCH-1:0]            w_ireq, w_dreq;
  logic [NCH-1:0]            w_ce_n, w_oe_n, w_we_n, w_drv, w_idone, w_ddone;
  logic [NCH-1:0][3:0]       w_be_n;
  logic [NCH-1:0][19:0]      w_addr;
  logic [NCH-1:0][31:0]      w_din, w_dout, w_rdata;
  logic                      r_ioor, r_door;

  // Valid window is 0x8000_0000..0x807F_FFFF; bit 22 picks the chip.
  assign w_iok = (bus.inst_addr[31:23] == 9'h100);
  assign w_dok = (bus.data_addr[31:23] == 9'h100);
  assign w_ireq[0] = bus.inst_req & w_iok & ~bus.inst_addr[22];
  assign w_ireq[1] = bus.inst_req & w_iok &  bus.inst_addr[22];
  assign w_dreq[0] = bus.data_req & w_dok & ~bus.data_addr[22];
  assign w_dreq[1] = bus.data_req & w_dok &  bus.data_addr[22];
  assign w_unused  = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      sram_chan #(.RD_WAIT(RD_WAIT), .WE_WIDTH(WE_WIDTH)) u_ch (
        .clk      (clk),
        .resetn   (resetn),
        .i_ireq   (w_ireq[c]),
        .i_iaddr  (bus.inst_addr[21:2]),
        .i_dreq   (w_dreq[c]),
        .i_dwe    (bus.data_we),
        .i_daddr  (bus.data_addr[21:2]),
        .i_dwdata (bus.data_wdata),
        .i_din    (w_din[c]),
        .o_ce_n   (w_ce_n[c]),
        .o_oe_n   (w_oe_n[c]),
        .o_we_n   (w_we_n[c]),
        .o_be_n   (w_be_n[c]),
        .o_addr   (w_addr[c]),
        .o_dout   (w_dout[c]),
        .o_drv    (w_drv[c]),
        .o_idone  (w_idone[c]),
        .o_ddone  (w_ddone[c]),
        .o_rdata  (w_rdata[c])
      );
    end
  endgenerate

  assign base_ram_data = w_drv[0] ? w_dout[0] : 32'bz;
  assign ext_ram_data  = w_drv[1] ? w_dout[1] : 32'bz;
  assign w_din[0]      = base_ram_data;
  assign w_din[1]      = ext_ram_data;

  assign base_ram_addr = w_addr[0];
  assign base_ram_be_n = w_be_n[0];
  assign base_ram_ce_n = w_ce_n[0];
  assign base_ram_oe_n = w_oe_n[0];
  assign base_ram_we_n = w_we_n[0];
  assign ext_ram_addr  = w_addr[1];
  assign ext_ram_be_n  = w_be_n[1];
  assign ext_ram_ce_n  = w_ce_n[1];
  assign ext_ram_oe_n  = w_oe_n[1];
  assign ext_ram_we_n  = w_we_n[1];

  // Out-of-range: answer next cycle with zero; self-clearing so a held request
  // is not accepted twice in a row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ioor <= 1'b0;
      r_door <= 1'b0;
    end else begin
      r_ioor <= bus.inst_req & ~w_iok & ~r_ioor;
      r_door <= bus.data_req & ~w_dok & ~r_door;
    end
  end

  assign bus.inst_done  = (|w_idone) | r_ioor;
  assign bus.data_done  = (|w_ddone) | r_door;
  assign bus.inst_rdata = ({32{w_idone[0]}} & w_rdata[0]) | ({32{w_idone[1]}} & w_rdata[1]);
  assign bus.data_rdata = ({32{w_ddone[0]}} & w_rdata[0]) | ({32{w_ddone[1]}} & w_rdata[1]);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with SRAM models and a done/rdata scoreboard.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if ifc();
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  sram_arbiter dut (
    .clk(clk), .resetn(resetn), .bus(ifc.slave),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
  );

  // Asynchronous-read SRAM models, writes committed on clock edges while we_n is low
  logic [31:0] mem_b [0:63];
  logic [31:0] mem_e [0:63];
  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n) ? mem_b[base_ram_addr[5:0]] : 32'bz;
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n) ? mem_e[ext_ram_addr[5:0]] : 32'bz;

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem_b[4] <= 32'h1234_5678;
      mem_b[8] <= 32'hCAFE_F00D;
      mem_e[2] <= 32'h1122_3344;
    end else begin
      if (!base_ram_ce_n && !base_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!base_ram_be_n[b]) mem_b[base_ram_addr[5:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!ext_ram_be_n[b]) mem_e[ext_ram_addr[5:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
    end
  end

  typedef struct { logic [31:0] rdata; bit chk; int cyc; } exp_t;
  exp_t iq[$];
  exp_t dq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop an expectation on every done pulse
  exp_t ei, ed;
  always @(negedge clk) begin
    if (resetn) begin
      if (ifc.inst_done) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst_done_unexpected at cyc %0d", cyc);
        end else begin
          ei = iq.pop_front();
          check("inst_done_cyc", cyc, ei.cyc);
          if (ei.chk) check("inst_rdata", ifc.inst_rdata, ei.rdata);
        end
      end
      if (ifc.data_done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_done_unexpected at cyc %0d", cyc);
        end else begin
          ed = dq.pop_front();
          check("data_done_cyc", cyc, ed.cyc);
          if (ed.chk) check("data_rdata", ifc.data_rdata, ed.rdata);
        end
      end
    end
  end

  a_ihold: assert property (@(posedge clk) disable iff (!resetn)
    (ifc.inst_req && !ifc.inst_done) |=> (ifc.inst_req || ifc.inst_done))
    else begin errors++; $display("FAIL inst_req_hold at cyc %0d", cyc); end
  a_dhold: assert property (@(posedge clk) disable iff (!resetn)
    (ifc.data_req && !ifc.data_done) |=> (ifc.data_req || ifc.data_done))
    else begin errors++; $display("FAIL data_req_hold at cyc %0d", cyc); end

  // Requesters: called between edges; the request is present in cycle T = cyc.
  task automatic do_inst(input logic [31:0] a, input logic [31:0] ex, input int lat);
    exp_t e;
    int n;
    ifc.inst_addr = a;
    ifc.inst_req  = 1'b1;
    e.rdata = ex; e.chk = 1'b1; e.cyc = cyc + lat;
    iq.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ifc.inst_done && n < 40);
    if (!ifc.inst_done) begin
      checks++; errors++;
      $display("FAIL inst_timeout addr %h", a);
      void'(iq.pop_back());
    end
    ifc.inst_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input logic [31:0] ex, input int lat);
    exp_t e;
    int n;
    ifc.data_addr  = a;
    ifc.data_we    = we;
    ifc.data_wdata = wd;
    ifc.data_req   = 1'b1;
    e.rdata = ex; e.chk = (we == 4'h0); e.cyc = cyc + lat;
    dq.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ifc.data_done && n < 40);
    if (!ifc.data_done) begin
      checks++; errors++;
      $display("FAIL data_timeout addr %h", a);
      void'(dq.pop_back());
    end
    ifc.data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t0;
    ifc.inst_req = 1'b0; ifc.inst_addr = '0;
    ifc.data_req = 1'b0; ifc.data_we = '0; ifc.data_addr = '0; ifc.data_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_inst_done",  ifc.inst_done, 0);
    check("rst_data_done",  ifc.data_done, 0);
    check("rst_inst_rdata", ifc.inst_rdata, 0);
    check("rst_data_rdata", ifc.data_rdata, 0);
    check("rst_base_pins",  {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n}, 7'h7F);
    check("rst_ext_pins",   {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_be_n}, 7'h7F);
    check("rst_base_addr",  base_ram_addr, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch read from BaseRAM word 4
    t0 = cyc;
    fork
      do_inst(32'h8000_0010, 32'h1234_5678, 3);
      begin
        wait_to(t0 + 1);
        check("fetch_addr_t1", base_ram_addr, 20'h4);
        check("fetch_oe_t1", base_ram_oe_n, 0);
        wait_to(t0 + 2);
        check("fetch_oe_t2", base_ram_oe_n, 0);
        check("fetch_ext_idle", ext_ram_ce_n, 1);
      end
    join

    // Byte store to ExtRAM word 2, byte 1
    t0 = cyc;
    fork
      do_data(32'h8040_0008, 4'b0010, 32'h0000_AB00, 32'h0, 4);
      begin
        wait_to(t0 + 1);
        check("st_t1", {ext_ram_ce_n, ext_ram_we_n, ext_ram_be_n}, {1'b0, 1'b1, 4'b1101});
        wait_to(t0 + 2);
        check("st_t2", {ext_ram_ce_n, ext_ram_we_n, ext_ram_be_n}, {1'b0, 1'b0, 4'b1101});
        check("st_bus_t2", ext_ram_data, 32'h0000_AB00);
        wait_to(t0 + 3);
        check("st_t3", {ext_ram_ce_n, ext_ram_we_n}, 2'b01);
      end
    join
    do_data(32'h8040_0008, 4'h0, 32'h0, 32'h1122_AB44, 3);

    // Same-SRAM conflict: data first, fetch afterwards
    t0 = cyc;
    fork
      do_data(32'h8000_0020, 4'h0, 32'h0, 32'hCAFE_F00D, 3);
      do_inst(32'h8000_0010, 32'h1234_5678, 7);
      begin
        wait_to(t0 + 1);
        check("conf_addr_data_first", base_ram_addr, 20'h8);
        wait_to(t0 + 5);
        check("conf_addr_fetch", base_ram_addr, 20'h4);
      end
    join

    // Parallel: fetch on BaseRAM, data on ExtRAM
    t0 = cyc;
    fork
      do_inst(32'h8000_0010, 32'h1234_5678, 3);
      do_data(32'h8040_0008, 4'h0, 32'h0, 32'h1122_AB44, 3);
      begin
        wait_to(t0 + 1);
        check("par_ce_both", {base_ram_ce_n, ext_ram_ce_n}, 2'b00);
      end
    join

    // Back-to-back fetches
    do_inst(32'h8000_0010, 32'h1234_5678, 3);
    do_inst(32'h8000_0020, 32'hCAFE_F00D, 3);

    // Out-of-range accesses
    t0 = cyc;
    fork
      do_data(32'h1FC0_0000, 4'h0, 32'h0, 32'h0, 1);
      begin
        wait_to(t0 + 1);
        check("oor_ce", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
      end
    join
    do_inst(32'h0000_1000, 32'h0, 1);
    do_data(32'h9040_0008, 4'hF, 32'hDEAD_BEEF, 32'h0, 1);
    do_data(32'h8040_0008, 4'h0, 32'h0, 32'h1122_AB44, 3);

    // Reset in the middle of a write
    t0 = cyc;
    ifc.data_addr = 32'h8000_0030; ifc.data_we = 4'hF; ifc.data_wdata = 32'h5555_AAAA;
    ifc.data_req = 1'b1;
    wait_to(t0 + 2);
    check("mid_we_low", base_ram_we_n, 0);
    resetn = 1'b0;
    #1;
    check("rst_mid_pins", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n}, 7'h7F);
    check("rst_mid_done", ifc.data_done, 0);
    ifc.data_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_data(32'h8000_0010, 4'h0, 32'h0, 32'h1234_5678, 3);

    repeat (4) @(negedge clk);
    check("iq_empty", iq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
